spike_rate_monitor: RTL

Downstream consumer of the leaky neuron's `spike` output. It detects rising edges of the spike line and counts them over a programmable window of clock cycles, reporting a per-window firing rate with a burst flag. It also measures the inter-spike interval (ISI) between consecutive edges. It sits beside the neuron inside the top-level wrapper and drives display/IO pins with the rate and ISI results.

---
 rtl/spike_rate_monitor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/spike_rate_monitor.sv
// Spike rate monitor: counts rising edges of the neuron spike line per programmable
// window, flags bursts, and measures the inter-spike interval between consecutive edges.
module spike_rate_monitor #(
    parameter int unsigned WIN_W    = 8,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned BURST_TH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             spike,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic             burst,
    output logic [7:0]       isi_out,
    output logic             isi_valid
);

    localparam int unsigned ISI_W = 8;

    logic             r_spike_q;
    logic [WIN_W-1:0] r_wcnt;
    logic [WIN_W-1:0] r_win_len;
    logic [CNT_W-1:0] r_scnt;
    logic [CNT_W-1:0] r_rate;
    logic             r_rate_valid;
    logic             r_burst;
    logic [ISI_W-1:0] r_isi_t;
    logic [ISI_W-1:0] r_isi_out;
    logic             r_isi_valid;
    logic             r_seen;

    logic             w_edge;
    logic [WIN_W-1:0] w_len;
    logic             w_last;
    logic             w_wrap;
    logic [CNT_W-1:0] w_scnt_inc;
    logic [CNT_W-1:0] w_rate_new;
    logic [ISI_W-1:0] w_isi_inc;

    assign w_edge     = en & spike & ~r_spike_q;
    // The length register is only trusted mid-window; at wcnt==0 the live input is the new L.
    // A zero length wraps to all-ones for L-1, which gives the 2^WIN_W window.
    assign w_len      = (r_wcnt == '0) ? window_len : r_win_len;
    assign w_last     = (r_wcnt == (w_len - WIN_W'(1)));
    assign w_wrap     = en & w_last;
    assign w_scnt_inc = (&r_scnt) ? r_scnt : r_scnt + CNT_W'(1);
    assign w_rate_new = w_edge ? w_scnt_inc : r_scnt;
    assign w_isi_inc  = (&r_isi_t) ? r_isi_t : r_isi_t + ISI_W'(1);

    // Edge-detect history follows spike regardless of enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_q <= 1'b0;
        end else begin
            r_spike_q <= spike;
        end
    end

    // Window position and latched length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt    <= '0;
            r_win_len <= '0;
        end else begin
            if (r_wcnt == '0) begin
                r_win_len <= window_len;
            end
            if (en) begin
                r_wcnt <= w_last ? '0 : r_wcnt + WIN_W'(1);
            end
        end
    end

    // Spike count and per-window rate report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scnt       <= '0;
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
            r_burst      <= 1'b0;
        end else begin
            r_rate_valid <= w_wrap;
            if (w_wrap) begin
                r_rate  <= w_rate_new;
                r_burst <= (32'(w_rate_new) >= 32'(BURST_TH));
                r_scnt  <= '0;
            end else if (w_edge) begin
                r_scnt <= w_scnt_inc;
            end
        end
    end

    // Inter-spike interval timer and report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_isi_t     <= '0;
            r_isi_out   <= '0;
            r_isi_valid <= 1'b0;
            r_seen      <= 1'b0;
        end else begin
            r_isi_valid <= w_edge & r_seen;
            if (w_edge) begin
                r_isi_t <= ISI_W'(1);
                r_seen  <= 1'b1;
                if (r_seen) begin
                    r_isi_out <= r_isi_t;
                end
            end else if (en) begin
                r_isi_t <= w_isi_inc;
            end
        end
    end

    assign rate_out   = r_rate;
    assign rate_valid = r_rate_valid;
    assign burst      = r_burst;
    assign isi_out    = r_isi_out;
    assign isi_valid  = r_isi_valid;

endmodule
